edge_event_arbiter: RTL and testbench

- Multi-channel rising-edge event scheduler.
- Per-channel positive-edge detection on synchronous level inputs; each detected edge is latched as a pending event.
- Pending events are shared onto one registered valid/ready event port under round-robin arbitration.
- Sits between synchronous status lines and a single event consumer (interrupt or handler logic).

---
 rtl/edge_event_arbiter_pkg.sv | 13 +
 rtl/edge_event_arbiter_rr_pick.sv | 31 +++
 rtl/edge_event_arbiter.sv | 107 ++++++++++
 tb/tb_edge_event_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/edge_event_arbiter_pkg.sv
// Shared definitions for the edge event arbiter.
// State encodings and default channel geometry.
package edge_event_arbiter_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int IDX_W_DEF = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } st_e;

endpackage

// File: rtl/edge_event_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit
// at or above ptr, wrapping from N_CH-1 back to 0.
module edge_event_arbiter_rr_pick
  import edge_event_arbiter_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  int c;

  // Walk from farthest to nearest so the nearest hit is written last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    c   = 0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      c = (int'(ptr) + k) % N_CH;
      if (req[c]) begin
        any = 1'b1;
        idx = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Rising-edge event capture on N_CH lines, shared onto one
// registered valid/ready port under round-robin arbitration.
module edge_event_arbiter
  import edge_event_arbiter_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  a,
  input  logic [N_CH-1:0]  mask,
  input  logic             evt_ready,
  input  logic             ovf_clr,
  output logic             evt_valid,
  output logic [IDX_W-1:0] evt_ch,
  output logic [N_CH-1:0]  pend,
  output logic [N_CH-1:0]  ovf
);

  st_e              state, state_n;
  logic [N_CH-1:0]  a_d;
  logic [N_CH-1:0]  cap;
  logic [N_CH-1:0]  clr;
  logic [N_CH-1:0]  pend_n;
  logic [N_CH-1:0]  ovf_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [IDX_W-1:0] ch_n;
  logic             valid_n;
  logic             hs;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;

  assign cap = a & ~a_d & mask;
  assign hs  = evt_valid & evt_ready;

  always_comb begin
    clr = '0;
    if (hs) clr[evt_ch] = 1'b1;
  end

  // Set beats clear on both pend and ovf.
  assign pend_n = (pend & ~clr) | cap;
  assign ovf_n  = (ovf & ~{N_CH{ovf_clr}}) |
                  (cap & pend & ~clr);

  edge_event_arbiter_rr_pick #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (pend),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_n = state;
    valid_n = evt_valid;
    ch_n    = evt_ch;
    ptr_n   = ptr;
    unique case (state)
      ST_IDLE: begin
        valid_n = 1'b0;
        if (pick_any) begin
          ch_n    = pick_idx;
          valid_n = 1'b1;
          state_n = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (evt_ready) begin
          valid_n = 1'b0;
          state_n = ST_IDLE;
          if (evt_ch == IDX_W'(N_CH - 1))
            ptr_n = '0;
          else
            ptr_n = evt_ch + IDX_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    a_d <= a;
    if (rst) begin
      state     <= ST_IDLE;
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      ptr       <= '0;
      pend      <= '0;
      ovf       <= '0;
    end else begin
      state     <= state_n;
      evt_valid <= valid_n;
      evt_ch    <= ch_n;
      ptr       <= ptr_n;
      pend      <= pend_n;
      ovf       <= ovf_n;
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomized bench for edge_event_arbiter against a
// cycle-level reference model of the event scheduler.
module tb_edge_event_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  a;
  logic [N-1:0]  mask;
  logic          evt_ready;
  logic          ovf_clr;
  logic          evt_valid;
  logic [IW-1:0] evt_ch;
  logic [N-1:0]  pend;
  logic [N-1:0]  ovf;

  int n_chk  = 0;
  int n_fail = 0;

  bit m_pend [N];
  bit m_ovf  [N];
  bit m_ad   [N];
  bit m_valid;
  int m_ch;
  int m_ptr;

  edge_event_arbiter #(
    .N_CH  (N),
    .IDX_W (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .mask      (mask),
    .evt_ready (evt_ready),
    .ovf_clr   (ovf_clr),
    .evt_valid (evt_valid),
    .evt_ch    (evt_ch),
    .pend      (pend),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic int vec(input bit v [N]);
    int r = 0;
    for (int i = 0; i < N; i++)
      if (v[i]) r |= (1 << i);
    return r;
  endfunction

  // One clock of the scheduler, from the behavioural rules.
  task automatic model_step(input bit r, input logic [N-1:0] av,
                            input logic [N-1:0] mv, input bit rdy,
                            input bit oc);
    bit old_pend [N];
    bit taken;
    bit cap;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0;
        m_ovf[i]  = 0;
        m_ad[i]   = av[i];
      end
      m_valid = 0;
      m_ch    = 0;
      m_ptr   = 0;
      return;
    end
    old_pend = m_pend;
    for (int i = 0; i < N; i++) begin
      cap   = av[i] && !m_ad[i] && mv[i];
      taken = m_valid && rdy && (m_ch == i);
      if (cap && old_pend[i] && !taken) m_ovf[i] = 1;
      else if (oc) m_ovf[i] = 0;
      if (cap) m_pend[i] = 1;
      else if (taken) m_pend[i] = 0;
      m_ad[i] = av[i];
    end
    if (m_valid) begin
      if (rdy) begin
        m_valid = 0;
        m_ptr   = (m_ch + 1) % N;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (old_pend[(m_ptr + k) % N]) begin
          m_valid = 1;
          m_ch    = (m_ptr + k) % N;
          break;
        end
      end
    end
  endtask

  // Drive at negedge, advance model, compare at next negedge.
  task automatic step(input bit r, input logic [N-1:0] av,
                      input logic [N-1:0] mv, input bit rdy,
                      input bit oc);
    rst       = r;
    a         = av;
    mask      = mv;
    evt_ready = rdy;
    ovf_clr   = oc;
    model_step(r, av, mv, rdy, oc);
    @(negedge clk);
    chk("evt_valid", int'(evt_valid), int'(m_valid));
    chk("evt_ch", int'(evt_ch), m_ch);
    chk("pend", int'(pend), vec(m_pend));
    chk("ovf", int'(ovf), vec(m_ovf));
  endtask

  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rm;
    bit           rr;

    step(1, 4'hF, 4'hF, 1, 0);
    step(1, 4'hF, 4'hF, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 4'hF, 4'hF, 1, 0);
      chk("quiet_valid", int'(evt_valid), 0);
      chk("quiet_pend", int'(pend), 0);
    end

    step(0, 4'h0, 4'hF, 1, 0);
    step(0, 4'h4, 4'hF, 1, 0);
    chk("ch2_pend", int'(pend), 4);
    step(0, 4'h4, 4'hF, 1, 0);
    chk("ch2_valid", int'(evt_valid), 1);
    chk("ch2_ch", int'(evt_ch), 2);
    step(0, 4'h4, 4'hF, 1, 0);
    chk("ch2_done", int'(evt_valid), 0);
    chk("ch2_clear", int'(pend), 0);

    step(0, 4'h0, 4'hF, 0, 0);
    step(0, 4'h6, 4'hF, 0, 0);
    step(0, 4'h6, 4'hF, 0, 0);
    chk("pre_rst_valid", int'(evt_valid), 1);
    step(1, 4'h6, 4'hF, 0, 0);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_pend", int'(pend), 0);
    chk("rst_ovf", int'(ovf), 0);
    step(0, 4'hE, 4'hF, 1, 0);
    step(0, 4'hE, 4'hF, 1, 0);
    chk("post_rst_ch3", int'(evt_ch), 3);
    step(0, 4'hE, 4'hF, 1, 0);

    rr = 1;
    ra = 4'hE;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(3) == 0) ra[i] = ~ra[i];
      rm = 4'hF;
      for (int i = 0; i < N; i++)
        if ($urandom_range(7) == 0) rm[i] = 1'b0;
      if ($urandom_range(3) == 0) rr = ~rr;
      step($urandom_range(199) == 0, ra, rm, rr,
           $urandom_range(15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
